// File: rtl/oldland_memory.sv
// oldland_memory -- memory-access stage of the Oldland pipeline.
//
// Takes the registered load/store request from execute and runs at most one
// req/ack transaction on the data bus. Non-memory instructions pass their
// writeback fields straight through with one cycle of latency.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_load, mem_store         request type from execute (store wins if both)
//   mem_width                   00 byte, 01 half, 10/11 word
//   mar, mdr                    byte address, right-justified store data
//   wr_val, wr_result, rd_sel   non-memory writeback fields
//   d_addr, d_bytesel,          data bus request, held stable while
//   d_wr_val, d_wr_en, d_access d_access is high until d_ack
//   d_ack, d_error, d_data      bus completion strobe, error flag, read data
//   busy                        combinational stall to the pipeline
//   wb_val, wb_en, wb_rd_sel    registered writeback to the writeback stage
//   data_abort                  one-cycle fault pulse (misaligned or bus error)
//
// Handshake: d_access is a request held with all bus fields stable until the
// cycle in which d_ack is high; that cycle completes the transaction, and
// d_error is only meaningful in it. Upstream holds its inputs while busy.
module oldland_memory (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] wr_val,
  input  logic        wr_result,
  input  logic [3:0]  rd_sel,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  output logic        d_access,
  input  logic        d_ack,
  input  logic        d_error,
  input  logic [31:0] d_data,
  output logic        busy,
  output logic [31:0] wb_val,
  output logic        wb_en,
  output logic [3:0]  wb_rd_sel,
  output logic        data_abort
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Kept as a named enum so checkers can bind to the current state directly.
  state_t      state;
  logic [3:0]  lat_rd;
  logic        lat_wr_result;
  logic [1:0]  lat_off;
  logic [1:0]  lat_width;

  logic        mem_req;
  logic        aligned;
  logic [3:0]  bytesel_next;
  logic [31:0] wr_data_next;
  logic [31:0] load_val;

  assign mem_req = mem_load | mem_store;

  always_comb begin
    aligned      = 1'b1;
    bytesel_next = 4'b1111;
    wr_data_next = mdr;
    unique case (mem_width)
      2'b00: begin
        aligned      = 1'b1;
        bytesel_next = 4'b0001 << mar[1:0];
        wr_data_next = {4{mdr[7:0]}};
      end
      2'b01: begin
        aligned      = ~mar[0];
        bytesel_next = mar[1] ? 4'b1100 : 4'b0011;
        wr_data_next = {2{mdr[15:0]}};
      end
      default: begin
        aligned      = (mar[1:0] == 2'b00);
        bytesel_next = 4'b1111;
        wr_data_next = mdr;
      end
    endcase
  end

  // Load data is zero-extended from the lanes selected by the latched offset.
  always_comb begin
    load_val = d_data;
    unique case (lat_width)
      2'b00:   load_val = {24'h0, d_data[{lat_off, 3'b000} +: 8]};
      2'b01:   load_val = lat_off[1] ? {16'h0, d_data[31:16]} : {16'h0, d_data[15:0]};
      default: load_val = d_data;
    endcase
  end

  assign busy = ((state == IDLE) & mem_req & aligned) | ((state == ACCESS) & ~d_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      d_addr        <= 32'h0;
      d_bytesel     <= 4'h0;
      d_wr_val      <= 32'h0;
      d_wr_en       <= 1'b0;
      d_access      <= 1'b0;
      wb_val        <= 32'h0;
      wb_en         <= 1'b0;
      wb_rd_sel     <= 4'h0;
      data_abort    <= 1'b0;
      lat_rd        <= 4'h0;
      lat_wr_result <= 1'b0;
      lat_off       <= 2'b00;
      lat_width     <= 2'b00;
    end else begin
      data_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!mem_req) begin
            wb_val    <= wr_val;
            wb_en     <= wr_result;
            wb_rd_sel <= rd_sel;
          end else if (aligned) begin
            state         <= ACCESS;
            d_access      <= 1'b1;
            d_addr        <= {mar[31:2], 2'b00};
            d_bytesel     <= bytesel_next;
            d_wr_en       <= mem_store;
            d_wr_val      <= wr_data_next;
            lat_rd        <= rd_sel;
            lat_wr_result <= wr_result;
            lat_off       <= mar[1:0];
            lat_width     <= mem_width;
            wb_en         <= 1'b0;
          end else begin
            data_abort <= 1'b1;
            wb_en      <= 1'b0;
          end
        end
        ACCESS: begin
          if (d_ack) begin
            state    <= IDLE;
            d_access <= 1'b0;
            if (d_error) begin
              wb_en      <= 1'b0;
              data_abort <= 1'b1;
            end else if (d_wr_en) begin
              wb_en <= 1'b0;
            end else begin
              wb_val    <= load_val;
              wb_en     <= lat_wr_result;
              wb_rd_sel <= lat_rd;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_memory.sv
module tb_oldland_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_load, mem_store;
  logic [1:0]  mem_width;
  logic [31:0] mar, mdr, wr_val;
  logic        wr_result;
  logic [3:0]  rd_sel;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en, d_access;
  logic        d_ack, d_error;
  logic [31:0] d_data;
  logic        busy;
  logic [31:0] wb_val;
  logic        wb_en;
  logic [3:0]  wb_rd_sel;
  logic        data_abort;

  int errors = 0;
  int checks = 0;

  // observations collected by the driver
  int          busy_cnt, acc_cnt, abort_cnt;
  logic        stable_ok;
  logic [31:0] cap_addr, cap_wr_val;
  logic [3:0]  cap_bytesel;
  logic        cap_wr_en;
  logic [31:0] post_wb_val;
  logic        post_wb_en, post_abort, post_access, abort_after;
  logic [3:0]  post_rd;
  logic [31:0] last_wr_val;

  oldland_memory dut (
    .clk(clk), .rst_n(rst_n), .mem_load(mem_load), .mem_store(mem_store),
    .mem_width(mem_width), .mar(mar), .mdr(mdr), .wr_val(wr_val),
    .wr_result(wr_result), .rd_sel(rd_sel), .d_addr(d_addr),
    .d_bytesel(d_bytesel), .d_wr_val(d_wr_val), .d_wr_en(d_wr_en),
    .d_access(d_access), .d_ack(d_ack), .d_error(d_error), .d_data(d_data),
    .busy(busy), .wb_val(wb_val), .wb_en(wb_en), .wb_rd_sel(wb_rd_sel),
    .data_abort(data_abort)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_aligned(input logic [1:0] w, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(w)) == 0;
  endfunction

  function automatic logic [3:0] exp_lanes(input logic [1:0] w, input logic [31:0] a);
    int n, base;
    n = nbytes(w);
    base = int'(a[1:0]) - (int'(a[1:0]) % n);
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] exp_store(input logic [1:0] w, input logic [31:0] md);
    logic [31:0] r;
    int n;
    n = nbytes(w);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((md >> (8 * (i % n))) & 32'hFF);
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] w, input logic [31:0] a,
                                           input logic [31:0] d);
    int n, base;
    logic [31:0] mask;
    n = nbytes(w);
    base = int'(a[1:0]) - (int'(a[1:0]) % n);
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 1);
    return (d >> (8 * base)) & mask;
  endfunction

  // ---------------- driver ----------------
  // Starts and ends 1 time unit after a rising edge. Issues one instruction,
  // plays the slave (acks after 'waits' wait cycles), then runs two nop cycles.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] md, input logic wr,
                        input logic [3:0] rd, input int waits, input logic [31:0] rdata,
                        input logic err);
    mem_load = ld; mem_store = st; mem_width = w; mar = a; mdr = md;
    wr_result = wr; rd_sel = rd; wr_val = $urandom; last_wr_val = wr_val;
    busy_cnt = 0; acc_cnt = 0; abort_cnt = 0; stable_ok = 1'b1;
    @(negedge clk);
    busy_cnt += int'(busy); acc_cnt += int'(d_access); abort_cnt += int'(data_abort);
    if ((ld || st) && is_aligned(w, a)) begin
      for (int c = 1; c <= waits + 1; c++) begin
        @(posedge clk); #1;
        d_ack = (c == waits + 1);
        d_error = err & d_ack;
        d_data = d_ack ? rdata : $urandom;
        @(negedge clk);
        busy_cnt += int'(busy); acc_cnt += int'(d_access); abort_cnt += int'(data_abort);
        if (c == 1) begin
          cap_addr = d_addr; cap_bytesel = d_bytesel; cap_wr_val = d_wr_val; cap_wr_en = d_wr_en;
        end else if (d_addr !== cap_addr || d_bytesel !== cap_bytesel ||
                     d_wr_val !== cap_wr_val || d_wr_en !== cap_wr_en) begin
          stable_ok = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    d_ack = 1'b0; d_error = 1'b0;
    mem_load = 1'b0; mem_store = 1'b0; wr_result = 1'b0;
    @(negedge clk);
    post_wb_val = wb_val; post_wb_en = wb_en; post_rd = wb_rd_sel;
    post_abort = data_abort; post_access = d_access;
    @(posedge clk); #1;
    @(negedge clk);
    abort_after = data_abort;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    mem_load = 0; mem_store = 0; mem_width = 0; mar = 0; mdr = 0; wr_val = 0;
    wr_result = 0; rd_sel = 0; d_ack = 0; d_error = 0; d_data = 0;
    #3;
    checks++;
    if ({d_addr, d_bytesel, d_wr_val, d_wr_en, d_access, wb_val, wb_en, wb_rd_sel,
         data_abort, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: d_access=%b d_addr=%h wb_en=%b busy=%b abort=%b, required all 0",
               d_access, d_addr, wb_en, busy, data_abort);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    logic [31:0] ev[$];
    logic        ee[$];
    logic [3:0]  er[$];
    for (int i = 0; i < 8; i++) begin
      wr_val    = (i < 3) ? 32'h1234 : $urandom;
      wr_result = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      rd_sel    = (i < 3) ? 4'd3 : 4'($urandom_range(0, 15));
      ev.push_back(wr_val); ee.push_back(wr_result); er.push_back(rd_sel);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || d_access !== 1'b0) begin
        errors++;
        $display("FAIL alu_no_bus: busy=%b d_access=%b, required 0/0", busy, d_access);
      end
      @(posedge clk); #1;
    end
    // the last instruction is registered; walk back through one more check cycle
    for (int i = 0; i < 8; i++) begin
      // replay expectations by re-driving the same sequence
      wr_val = ev[i]; wr_result = ee[i]; rd_sel = er[i];
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (wb_val !== ev[i] || wb_en !== ee[i] || wb_rd_sel !== er[i]) begin
        errors++;
        $display("FAIL alu_pass[%0d]: wb=%h/%b/%0d, required %h/%b/%0d",
                 i, wb_val, wb_en, wb_rd_sel, ev[i], ee[i], er[i]);
      end
    end
    wr_result = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_load();
    run_op(1, 0, 2'b00, 32'h103, 32'h0, 1, 4'd5, 2, 32'hAABBCCDD, 0);
    checks++;
    if (cap_addr !== 32'h100 || cap_bytesel !== 4'b1000 || cap_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL byte_load_bus: addr=%h sel=%b wr_en=%b, required 00000100/1000/0",
               cap_addr, cap_bytesel, cap_wr_en);
    end
    checks++;
    if (busy_cnt !== 3 || acc_cnt !== 3) begin
      errors++;
      $display("FAIL byte_load_busy: busy=%0d access=%0d cycles, required 3/3", busy_cnt, acc_cnt);
    end
    checks++;
    if (post_wb_val !== 32'hAA || post_wb_en !== 1'b1 || post_rd !== 4'd5 || post_access !== 1'b0) begin
      errors++;
      $display("FAIL byte_load_wb: wb=%h/%b/%0d access=%b, required 000000aa/1/5/0",
               post_wb_val, post_wb_en, post_rd, post_access);
    end
  endtask

  task automatic test_half_store();
    run_op(0, 1, 2'b01, 32'h202, 32'h0000BEEF, 1, 4'd6, 0, 32'h0, 0);
    checks++;
    if (cap_wr_en !== 1'b1 || cap_bytesel !== 4'b1100 || cap_wr_val !== 32'hBEEFBEEF ||
        cap_addr !== 32'h200) begin
      errors++;
      $display("FAIL half_store_bus: wr_en=%b sel=%b data=%h addr=%h, required 1/1100/beefbeef/00000200",
               cap_wr_en, cap_bytesel, cap_wr_val, cap_addr);
    end
    checks++;
    if (busy_cnt !== 1 || post_wb_en !== 1'b0 || post_abort !== 1'b0) begin
      errors++;
      $display("FAIL half_store_wb: busy=%0d wb_en=%b abort=%b, required 1/0/0",
               busy_cnt, post_wb_en, post_abort);
    end
  endtask

  task automatic test_misaligned();
    run_op(1, 0, 2'b10, 32'h301, 32'h0, 1, 4'd4, 0, 32'h0, 0);
    checks++;
    if (busy_cnt !== 0 || acc_cnt !== 0 || post_access !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_bus: busy=%0d access=%0d, required 0/0", busy_cnt, acc_cnt);
    end
    checks++;
    if (post_abort !== 1'b1 || post_wb_en !== 1'b0 || abort_after !== 1'b0 || abort_cnt !== 0) begin
      errors++;
      $display("FAIL misaligned_abort: abort=%b wb_en=%b abort_next=%b, required 1/0/0",
               post_abort, post_wb_en, abort_after);
    end
  endtask

  task automatic test_bus_error();
    run_op(1, 0, 2'b10, 32'h400, 32'h0, 1, 4'd2, 1, 32'h12345678, 1);
    checks++;
    if (post_abort !== 1'b1 || post_wb_en !== 1'b0 || abort_after !== 1'b0 || post_access !== 1'b0) begin
      errors++;
      $display("FAIL bus_error: abort=%b wb_en=%b abort_next=%b access=%b, required 1/0/0/0",
               post_abort, post_wb_en, abort_after, post_access);
    end
    run_op(0, 0, 2'b00, 32'h0, 32'h0, 1, 4'd9, 0, 32'h0, 0);
    checks++;
    if (post_wb_val !== last_wr_val || post_wb_en !== 1'b1 || post_rd !== 4'd9 || busy_cnt !== 0) begin
      errors++;
      $display("FAIL after_error_alu: wb=%h/%b/%0d, required %h/1/9",
               post_wb_val, post_wb_en, post_rd, last_wr_val);
    end
  endtask

  task automatic test_back_to_back();
    mem_load = 1; mem_store = 0; mem_width = 2'b10; mar = 32'h10; rd_sel = 4'd2; wr_result = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_req_busy: busy=%b, required 1", busy);
    end
    @(posedge clk); #1;
    d_ack = 1; d_data = 32'hCAFE0001;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || d_access !== 1'b1) begin
      errors++; $display("FAIL b2b_ack_cycle: busy=%b access=%b, required 0/1", busy, d_access);
    end
    @(posedge clk); #1;
    d_ack = 0; mem_load = 0; wr_val = 32'h55; wr_result = 1; rd_sel = 4'd7;
    @(negedge clk);
    checks++;
    if (wb_val !== 32'hCAFE0001 || wb_en !== 1'b1 || wb_rd_sel !== 4'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load_wb: wb=%h/%b/%0d, required cafe0001/1/2", wb_val, wb_en, wb_rd_sel);
    end
    @(posedge clk); #1;
    wr_result = 0;
    @(negedge clk);
    checks++;
    if (wb_val !== 32'h55 || wb_en !== 1'b1 || wb_rd_sel !== 4'd7) begin
      errors++;
      $display("FAIL b2b_alu_wb: wb=%h/%b/%0d, required 00000055/1/7", wb_val, wb_en, wb_rd_sel);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    mem_load = 1; mem_store = 0; mem_width = 2'b10; mar = 32'h500; rd_sel = 4'd1; wr_result = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (d_access !== 1'b1) begin
      errors++; $display("FAIL mid_reset_setup: d_access=%b, required 1", d_access);
    end
    #2;
    mem_load = 0; wr_result = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d_addr, d_bytesel, d_wr_val, d_wr_en, d_access, wb_val, wb_en, wb_rd_sel,
         data_abort, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: d_access=%b d_addr=%h wb_en=%b busy=%b, required all 0",
               d_access, d_addr, wb_en, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1, 0, 2'b01, 32'h602, 32'h0, 1, 4'd8, 1, 32'h89ABCDEF, 0);
    checks++;
    if (post_wb_val !== 32'h000089AB || post_wb_en !== 1'b1 || post_rd !== 4'd8 || acc_cnt !== 2) begin
      errors++;
      $display("FAIL after_reset_load: wb=%h/%b/%0d access=%0d, required 000089ab/1/8/2",
               post_wb_val, post_wb_en, post_rd, acc_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic ld, st, wr, err, mem, acc, ok_load;
      logic [1:0] w;
      logic [31:0] a, md, rdata;
      logic [3:0] rd;
      int waits, kind;
      kind = $urandom_range(0, 3);
      ld = (kind == 1) || (kind == 3);
      st = (kind == 2) || (kind == 3);
      w = 2'($urandom_range(0, 3));
      a = $urandom; md = $urandom; rdata = $urandom;
      wr = 1'($urandom_range(0, 1)); rd = 4'($urandom_range(0, 15));
      waits = $urandom_range(0, 3);
      err = ($urandom_range(0, 5) == 0);
      run_op(ld, st, w, a, md, wr, rd, waits, rdata, err);

      mem = ld | st;
      acc = mem && is_aligned(w, a);
      ok_load = acc && !err && !st;
      checks++;
      if (busy_cnt != (acc ? waits + 1 : 0) || acc_cnt != (acc ? waits + 1 : 0) || !stable_ok) begin
        errors++;
        $display("FAIL rand_timing[%0d]: busy=%0d access=%0d stable=%b, required %0d/%0d/1",
                 i, busy_cnt, acc_cnt, stable_ok, acc ? waits + 1 : 0, acc ? waits + 1 : 0);
      end
      if (acc) begin
        checks++;
        if (cap_addr !== {a[31:2], 2'b00} || cap_bytesel !== exp_lanes(w, a) ||
            cap_wr_en !== st || (st && cap_wr_val !== exp_store(w, md))) begin
          errors++;
          $display("FAIL rand_bus[%0d]: addr=%h sel=%b wr_en=%b data=%h, required %h/%b/%b/%h",
                   i, cap_addr, cap_bytesel, cap_wr_en, cap_wr_val, {a[31:2], 2'b00},
                   exp_lanes(w, a), st, exp_store(w, md));
        end
      end
      checks++;
      if (post_abort !== (mem && (!acc || err)) || abort_after !== 1'b0 || abort_cnt !== 0 ||
          post_wb_en !== (mem ? (ok_load & wr) : wr)) begin
        errors++;
        $display("FAIL rand_resp[%0d]: abort=%b wb_en=%b, required %b/%b",
                 i, post_abort, post_wb_en, mem && (!acc || err), mem ? (ok_load & wr) : wr);
      end
      if (!mem || ok_load) begin
        checks++;
        if (post_wb_val !== (mem ? exp_load(w, a, rdata) : last_wr_val) || post_rd !== rd) begin
          errors++;
          $display("FAIL rand_wb[%0d]: wb_val=%h rd=%0d, required %h/%0d", i, post_wb_val, post_rd,
                   mem ? exp_load(w, a, rdata) : last_wr_val, rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_bus_error();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oldland_memory.md
# oldland_memory

Memory-access stage of the Oldland pipeline, directly downstream of the execute stage. Consumes the registered load/store request, address (MAR), store data (MDR) and writeback fields from execute, and runs a single-outstanding req/ack transaction on the data bus. Produces the registered writeback (register select, value, enable) for the writeback stage, a `busy` stall to the pipeline and a `data_abort` pulse back to execute.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_load`  in  1  execute output: current instruction is a load.
- `mem_store`  in  1  execute output: current instruction is a store.
- `mem_width`  in  2  access width: 00 byte, 01 half, 10 word, 11 treated as word.
- `mar`  in  32  byte address of the access.
- `mdr`  in  32  store data, right-justified.
- `wr_val`  in  32  non-memory writeback value from execute.
- `wr_result`  in  1  instruction writes a register.
- `rd_sel`  in  4  destination register.
- `d_addr`  out  32  bus address, word-aligned (`mar[31:2], 2'b00`).
- `d_bytesel`  out  4  byte-lane enables, bit n = bits [8n+7:8n].
- `d_wr_val`  out  32  bus write data, lanes replicated.
- `d_wr_en`  out  1  transaction is a write.
- `d_access`  out  1  transaction request, held until ack.
- `d_ack`  in  1  single-cycle completion strobe.
- `d_error`  in  1  bus error, valid only with `d_ack`.
- `d_data`  in  32  read data, valid with `d_ack`.
- `busy`  out  1  combinational stall; upstream holds inputs stable while high.
- `wb_val`  out  32  writeback value.
- `wb_en`  out  1  writeback enable.
- `wb_rd_sel`  out  4  writeback register.
- `data_abort`  out  1  one-cycle fault pulse.

## Operation
- FSM states: IDLE, ACCESS.
- Alignment: word needs `mar[1:0]==00`, half needs `mar[0]==0`, byte always aligned.
- IDLE, no load/store: next edge registers `wb_val<=wr_val`, `wb_en<=wr_result`, `wb_rd_sel<=rd_sel`. No bus activity.
- IDLE, aligned load/store: next edge -> ACCESS; registers `d_access=1`, `d_addr`, `d_bytesel`, `d_wr_en=mem_store`, `d_wr_val`. Also latches `rd_sel`, `wr_result`, `mar[1:0]`, width. `wb_en<=0`.
- IDLE, misaligned load/store: no transaction; next edge `data_abort<=1`, `wb_en<=0`; stay IDLE.
- Byte lanes: byte `4'b0001<<mar[1:0]`, half `mar[1]?1100:0011`, word `1111`.
- Store data: byte `{4{mdr[7:0]}}`, half `{2{mdr[15:0]}}`, word `mdr`.
- ACCESS: inputs ignored; bus outputs stable until `d_ack`.
- ACCESS with `d_ack & !d_error`: next edge -> IDLE, `d_access<=0`. For loads, `wb_val<=` extracted data, zero-extended: byte `d_data[8*off+7 -: 8]`, half `off[1]` selects upper/lower 16 bits. `wb_en<=` latched `wr_result`, `wb_rd_sel<=` latched rd. For stores, `wb_en<=0`.
- ACCESS with `d_ack & d_error`: -> IDLE, `d_access<=0`, `wb_en<=0`, `data_abort<=1` for one cycle.
- `busy = (IDLE & (mem_load|mem_store) & aligned) | (ACCESS & !d_ack)`.
- If `mem_load` and `mem_store` are both set, the access is a store.

## Timing
- Reset (async, any state including mid-ACCESS): state IDLE. All outputs 0: `d_access`, `d_wr_en`, `d_addr`, `d_bytesel`, `d_wr_val`, `wb_*`, `data_abort`. `busy` follows its equation, so it reads 0 if no request is present. No ack is expected after reset; a stray `d_ack` in IDLE is ignored.
- Non-memory latency: 1 cycle, back-to-back every cycle.
- Memory: request cycle N (busy=1), `d_access` high from N+1. Ack in cycle N+k (k>=1) makes busy low in that cycle; `wb_*` valid at N+k+1. A zero-wait slave (ack in N+1) gives 2-cycle occupancy.
- A new instruction accepted in the ack cycle's following cycle; no idle bubble required.
- `data_abort` high exactly one cycle, never with `wb_en`.

## Test plan
- ALU passthrough: wr_val=0x1234, wr_result=1, rd_sel=3 for 3 consecutive cycles -> wb_val=0x1234, wb_en=1, wb_rd_sel=3 each following cycle; d_access never asserted.
- Byte load: mar=0x103, width=00, rd=5; slave acks after 2 waits with d_data=0xAABBCCDD -> d_addr=0x100, d_bytesel=1000, busy high 3 cycles, then wb_val=0x000000AA, wb_en=1, wb_rd_sel=5.
- Half store: mar=0x202, width=01, mdr=0x0000BEEF, zero-wait ack -> d_wr_en=1, d_bytesel=1100, d_wr_val=0xBEEFBEEF, wb_en=0.
- Misaligned word load mar=0x301 -> no d_access, busy=0, data_abort pulses 1 cycle, wb_en=0.
- Bus error: word load mar=0x400, ack with d_error=1 -> data_abort 1 cycle, wb_en=0, FSM IDLE; following ALU op writes back normally.
- Reset asserted mid-ACCESS -> d_access drops immediately, all outputs 0; after release, a fresh load completes correctly.
